decl_arbiter: RTL and testbench
===============================

DECL_ARBITER -- requirements
Module: decl_arbiter

Interface
REQ-001 Parameter: MAX_STALL, default 15, max consecutive idle owner cycles inside a statement before abort (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 req_valid  input  2  bit i: requester i presents a character on req_data_i.
REQ-005 req_data0, req_data1  input  8  ASCII character from requester 0 / 1.
REQ-006 req_ready  output  2  bit i: character from requester i is accepted this cycle (transfer = valid & ready).
REQ-007 chk_in  output  8  character driven to the shared declaration checker.
REQ-008 chk_step  output  1  checker advances one character on this clock edge.
REQ-009 chk_out  input  1  checker verdict, valid the cycle after the terminating ';' is stepped.
REQ-010 res_valid  output  1  one-cycle pulse: statement verdict available.
REQ-011 res_id  output  1  requester the verdict belongs to.
REQ-012 res_ok  output  1  1 = legal declaration; 0 = illegal or aborted.
REQ-013 res_abort  output  1  1 = statement terminated by stall timeout.

Function
REQ-014 The block SHALL grant the checker to one requester per statement (characters up to and including ';'); no interleaving within a statement.
REQ-015 FSM states SHALL be IDLE, RUN, RESULT.
REQ-016 IDLE: if any req_valid, SHALL select owner by round-robin (priority bit prio; prio holds the preferred id), load owner, clear stall_cnt and abort flag, go RUN; req_ready=0 and chk_step=0 in IDLE.
REQ-017 RUN: req_ready[owner]=1 while stall_cnt<MAX_STALL; non-owner ready SHALL be 0.
REQ-018 RUN transfer: chk_in=req_data_owner, chk_step=1 in the same cycle (zero-latency pass-through), stall_cnt cleared; if character is ';' (8'h3B) go RESULT.
REQ-019 RUN, owner valid=0 and stall_cnt<MAX_STALL: stall_cnt increments, chk_step=0.
REQ-020 RUN, stall_cnt==MAX_STALL: req_ready=0, chk_in=';', chk_step=1, abort flag set, go RESULT.
REQ-021 RESULT: res_valid=1, res_id=owner, res_ok=chk_out & ~abort, res_abort=abort; prio set to ~owner; go IDLE.
REQ-022 Outside RESULT, res_valid/res_ok/res_abort SHALL be 0; outside transfer/abort cycles chk_step=0 and chk_in=8'h20.
REQ-023 Back-to-back: earliest new grant is the cycle after RESULT (IDLE cycle), giving 2 cycles of overhead per statement.
REQ-024 Simultaneous valid in IDLE SHALL grant prio; a lone valid is granted regardless of prio.
REQ-025 An empty statement (';' only) SHALL be passed through and its verdict reported normally.

Reset
REQ-026 On reset: state=IDLE, owner=0, prio=0, stall_cnt=0, abort=0; all outputs 0 except chk_in=8'h20.
REQ-027 Reset mid-statement SHALL discard the statement with no res_valid; the checker shares the same reset line, so both restart in the initial state.

Structure
REQ-028 Package decl_arb_pkg SHALL hold state encoding, CH_SEMI=8'h3B, CH_SPACE=8'h20, and the MAX_STALL default.
REQ-029 One sub-module, rr_pick2 (combinational 2-way round-robin picker: valid[1:0], prio -> grant id, any), SHALL be instantiated.
REQ-030 stall_cnt width SHALL be 8 bits; owner and prio 1 bit each.

Verification
REQ-031 After reset req0 sends "int a;" alone -> 6 chk_step pulses carrying the same chars, then res_valid with res_id=0, res_ok=1, res_abort=0.
REQ-032 Both valid from IDLE, req0 "int x;", req1 "int 1;" -> req0 served first (res_ok=1), then req1 (res_id=1, res_ok=0); req_ready never high for both.
REQ-033 req1 sends "int" then drops valid for 16 cycles (MAX_STALL=15) -> on 16th idle cycle chk_in=';', chk_step=1, req_ready=0; next cycle res_id=1, res_ok=0, res_abort=1.
REQ-034 req0 always valid with repeated "int b;" plus req1 valid -> grants alternate 0,1,0,1 (no starvation).
REQ-035 Assert reset asynchronously after req0 has sent "in" -> outputs clear immediately, no res_valid; then "int c;" -> res_ok=1.
REQ-036 req0 sends ";" -> one step, res_valid, res_ok=0 (checker rejects empty statement), res_abort=0.

Source files
------------

// File: rtl/decl_arb_pkg.sv
// Shared definitions for the declaration-checker arbiter.
// State encoding, framing characters and the default stall limit.
package decl_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_RESULT = 2'd2
   } state_t;

   localparam logic [7:0] CH_SEMI  = 8'h3B;
   localparam logic [7:0] CH_SPACE = 8'h20;

   localparam int MAX_STALL_DEF = 15;

endpackage

// File: rtl/decl_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
// valid[1:0], prio -> id (granted requester), any (some request).
module rr_pick2 (
   input  logic [1:0] valid,
   input  logic       prio,
   output logic       id,
   output logic       any
);

   assign any = |valid;

   // A contested pick goes to prio; a lone request wins outright.
   assign id = (valid == 2'b11) ? prio : valid[1];

endmodule

// File: rtl/decl_arbiter.sv
// Grants a shared declaration checker to one of two requesters for a
// whole ';'-terminated statement, then reports that statement's verdict.
// Ports: clk, reset (async, active-high);
//   req_valid/req_data0/req_data1 -> req_ready : requester side;
//   chk_in/chk_step -> chk_out : checker side;
//   res_valid/res_id/res_ok/res_abort : per-statement verdict pulse.
module decl_arbiter
   import decl_arb_pkg::*;
#(
   parameter int MAX_STALL = MAX_STALL_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_valid,
   input  logic [7:0] req_data0,
   input  logic [7:0] req_data1,
   output logic [1:0] req_ready,
   output logic [7:0] chk_in,
   output logic       chk_step,
   input  logic       chk_out,
   output logic       res_valid,
   output logic       res_id,
   output logic       res_ok,
   output logic       res_abort
);

   localparam logic [7:0] STALL_LIM = 8'(MAX_STALL);

   state_t     state;
   logic       owner;
   logic       prio;
   logic [7:0] stall_cnt;
   logic       abort_q;

   logic       pick_id;
   logic       pick_any;
   logic       run;
   logic       at_lim;
   logic       own_valid;
   logic [7:0] own_data;
   logic       xfer;
   logic       timeout;

   rr_pick2 u_pick (
      .valid (req_valid),
      .prio  (prio),
      .id    (pick_id),
      .any   (pick_any)
   );

   assign run       = (state == S_RUN);
   assign at_lim    = (stall_cnt == STALL_LIM);
   assign own_valid = owner ? req_valid[1] : req_valid[0];
   assign own_data  = owner ? req_data1 : req_data0;

   assign xfer    = run & ~at_lim & own_valid;
   assign timeout = run & at_lim;

   // Character path is a pure pass-through so the checker steps in
   // the same cycle the requester's character is accepted.
   always_comb begin
      req_ready = 2'b00;
      if (run && !at_lim) begin
         req_ready = owner ? 2'b10 : 2'b01;
      end
   end

   assign chk_step = xfer | timeout;

   // A timeout injects ';' so the checker closes the statement too.
   assign chk_in = xfer    ? own_data :
                   timeout ? CH_SEMI  : CH_SPACE;

   assign res_valid = (state == S_RESULT);
   assign res_id    = owner;
   assign res_ok    = res_valid & chk_out & ~abort_q;
   assign res_abort = res_valid & abort_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         owner     <= 1'b0;
         prio      <= 1'b0;
         stall_cnt <= 8'd0;
         abort_q   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pick_any) begin
                  owner     <= pick_id;
                  stall_cnt <= 8'd0;
                  abort_q   <= 1'b0;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (timeout) begin
                  abort_q <= 1'b1;
                  state   <= S_RESULT;
               end else if (xfer) begin
                  stall_cnt <= 8'd0;
                  if (own_data == CH_SEMI) begin
                     state <= S_RESULT;
                  end
               end else begin
                  stall_cnt <= stall_cnt + 8'd1;
               end
            end
            S_RESULT: begin
               prio  <= ~owner;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decl_arbiter.sv
// Self-checking bench for decl_arbiter with a statement-level model
// and a behavioural declaration checker stub.
module tb_decl_arbiter;

   localparam int MS = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req_valid;
   logic [7:0] req_data0;
   logic [7:0] req_data1;
   logic [1:0] req_ready;
   logic [7:0] chk_in;
   logic       chk_step;
   logic       chk_out;
   logic       res_valid;
   logic       res_id;
   logic       res_ok;
   logic       res_abort;

   decl_arbiter #(.MAX_STALL(MS)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data0 (req_data0),
      .req_data1 (req_data1),
      .req_ready (req_ready),
      .chk_in    (chk_in),
      .chk_step  (chk_step),
      .chk_out   (chk_out),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_ok    (res_ok),
      .res_abort (res_abort)
   );

   always #5 clk = ~clk;

   typedef struct {
      string txt;
      int    gat;
      int    glen;
   } stmt_t;

   typedef struct {
      bit    id;
      bit    ok;
      bit    ab;
      string s;
   } exp_t;

   stmt_t sq0[$];
   stmt_t sq1[$];
   exp_t  eq[$];

   string ptxt[10];
   bit    pok[10];

   int         total = 0;
   int         bad = 0;
   int         idx[2];
   int         gleft[2];
   bit         abt[2];
   bit         v[2];
   logic [7:0] d[2];
   bit         prio_m;
   string      sbuf;
   string      cbuf;
   bit         pstep;
   logic [7:0] pch;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(string s);
      for (int k = 0; k < 10; k++) begin
         if (ptxt[k] == s) return pok[k];
      end
      return 1'b0;
   endfunction

   function automatic int qsz(int i);
      return (i != 0) ? sq1.size() : sq0.size();
   endfunction

   function automatic stmt_t qhead(int i);
      return (i != 0) ? sq1[0] : sq0[0];
   endfunction

   function automatic void qpop(int i);
      if (i != 0) void'(sq1.pop_front());
      else void'(sq0.pop_front());
   endfunction

   task automatic add(int i, string t, int g_at, int g_len);
      stmt_t s;
      s.txt  = t;
      s.gat  = g_at;
      s.glen = g_len;
      if (i != 0) sq1.push_back(s);
      else sq0.push_back(s);
   endtask

   // Statement-level model: round robin over pending statements.
   function automatic void plan();
      int    a = 0;
      int    b = 0;
      bit    pick;
      stmt_t s;
      exp_t  e;
      while (a < sq0.size() || b < sq1.size()) begin
         if (a < sq0.size() && b < sq1.size()) pick = prio_m;
         else pick = (b < sq1.size());
         if (pick) begin
            s = sq1[b];
            b++;
         end else begin
            s = sq0[a];
            a++;
         end
         e.id = pick;
         e.ab = (s.glen >= MS);
         if (e.ab) e.s = $sformatf("%s;", s.txt.substr(0, s.gat - 1));
         else e.s = s.txt;
         e.ok = !e.ab && legal(s.txt);
         eq.push_back(e);
         prio_m = ~pick;
      end
   endfunction

   task automatic cyc();
      stmt_t s;
      exp_t  e;
      bit    x[2];
      @(posedge clk);
      #1;
      chk_out = 1'b0;
      if (pstep) begin
         if (pch == 8'h3B) begin
            chk_out = legal($sformatf("%s;", cbuf));
            cbuf = "";
         end else begin
            cbuf = $sformatf("%s%c", cbuf, pch);
         end
      end
      for (int i = 0; i < 2; i++) begin
         v[i] = 1'b0;
         d[i] = 8'($urandom);
         if (qsz(i) > 0 && gleft[i] == 0) begin
            s = qhead(i);
            v[i] = 1'b1;
            d[i] = s.txt[idx[i]];
         end
      end
      req_valid = {v[1], v[0]};
      req_data0 = d[0];
      req_data1 = d[1];
      @(negedge clk);
      chk("both_ready", {31'd0, &req_ready}, 0);
      for (int i = 0; i < 2; i++) begin
         x[i] = v[i] && req_ready[i];
         if (x[i]) begin
            chk("step_xfer", {31'd0, chk_step}, 1);
            chk("chin_xfer", {24'd0, chk_in}, {24'd0, d[i]});
         end
      end
      if (chk_step && !x[0] && !x[1]) begin
         chk("abort_chin", {24'd0, chk_in}, 32'h3B);
         chk("abort_ready", {30'd0, req_ready}, 0);
      end
      if (!chk_step) chk("idle_chin", {24'd0, chk_in}, 32'h20);
      if (chk_step) sbuf = $sformatf("%s%c", sbuf, chk_in);
      if (res_valid) begin
         chk("res_expected", {31'd0, eq.size() > 0}, 1);
         if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("res_id", {31'd0, res_id}, {31'd0, e.id});
            chk("res_ok", {31'd0, res_ok}, {31'd0, e.ok});
            chk("res_abort", {31'd0, res_abort}, {31'd0, e.ab});
            chk("res_chars", {31'd0, sbuf == e.s}, 1);
         end
         sbuf = "";
      end else begin
         chk("res_quiet", {30'd0, res_ok, res_abort}, 0);
      end
      pstep = chk_step;
      pch   = chk_in;
      for (int i = 0; i < 2; i++) begin
         if (qsz(i) > 0) begin
            s = qhead(i);
            if (gleft[i] > 0) begin
               gleft[i]--;
               if (gleft[i] == 0 && abt[i]) begin
                  qpop(i);
                  idx[i] = 0;
                  abt[i] = 1'b0;
               end
            end else if (x[i]) begin
               idx[i]++;
               if (idx[i] == s.txt.len()) begin
                  qpop(i);
                  idx[i] = 0;
               end else if (idx[i] == s.gat && s.glen > 0) begin
                  gleft[i] = s.glen;
                  abt[i]   = (s.glen >= MS);
               end
            end
         end
      end
   endtask

   task automatic run_phase(string tag);
      int n = 0;
      plan();
      while ((eq.size() > 0 || sq0.size() > 0 || sq1.size() > 0)
             && n < 3000) begin
         cyc();
         n++;
      end
      chk(tag, {31'd0, n < 3000}, 1);
   endtask

   task automatic clear_env();
      sq0.delete();
      sq1.delete();
      eq.delete();
      for (int i = 0; i < 2; i++) begin
         idx[i]   = 0;
         gleft[i] = 0;
         abt[i]   = 1'b0;
         v[i]     = 1'b0;
      end
      sbuf      = "";
      cbuf      = "";
      pstep     = 1'b0;
      chk_out   = 1'b0;
      prio_m    = 1'b0;
      req_valid = 2'b00;
   endtask

   initial begin
      int    n;
      int    ri;
      string t;
      ptxt[0] = "int a;";    pok[0] = 1;
      ptxt[1] = "int x;";    pok[1] = 1;
      ptxt[2] = "int 1;";    pok[2] = 0;
      ptxt[3] = ";";         pok[3] = 0;
      ptxt[4] = "int b;";    pok[4] = 1;
      ptxt[5] = "int c;";    pok[5] = 1;
      ptxt[6] = "char q;";   pok[6] = 1;
      ptxt[7] = "int;";      pok[7] = 0;
      ptxt[8] = "intz;";     pok[8] = 0;
      ptxt[9] = "float f2;"; pok[9] = 1;
      reset = 1'b1;
      req_data0 = 8'h00;
      req_data1 = 8'h00;
      clear_env();
      repeat (2) @(negedge clk);
      chk("rst_ready", {30'd0, req_ready}, 0);
      chk("rst_step", {31'd0, chk_step}, 0);
      chk("rst_chin", {24'd0, chk_in}, 32'h20);
      chk("rst_res", {29'd0, res_valid, res_ok, res_abort}, 0);
      chk("rst_res_id", {31'd0, res_id}, 0);
      reset = 1'b0;

      add(0, "int x;", 0, 0);
      add(1, "int 1;", 0, 0);
      run_phase("both_from_idle");

      add(0, ";", 0, 0);
      run_phase("empty_stmt");

      add(0, "int a;", 0, 0);
      run_phase("lone_req0");

      add(1, "int x;", 3, MS + 1);
      run_phase("req1_timeout");

      add(0, "int b;", 4, MS - 1);
      add(0, "int ab;", 5, MS);
      run_phase("stall_boundary");

      for (int k = 0; k < 4; k++) add(0, "int b;", 0, 0);
      for (int k = 0; k < 3; k++) add(1, "int c;", 0, 0);
      run_phase("alternate");

      add(0, "int c;", 0, 0);
      n = 0;
      while (idx[0] < 2 && n < 20) begin
         cyc();
         n++;
      end
      chk("pre_reset_progress", idx[0], 2);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("arst_ready", {30'd0, req_ready}, 0);
      chk("arst_step", {31'd0, chk_step}, 0);
      chk("arst_chin", {24'd0, chk_in}, 32'h20);
      chk("arst_res", {31'd0, res_valid}, 0);
      clear_env();
      repeat (2) @(negedge clk);
      chk("arst_hold_res", {31'd0, res_valid}, 0);
      reset = 1'b0;
      add(0, "int c;", 0, 0);
      run_phase("after_reset");

      for (int k = 0; k < 30; k++) begin
         ri = $urandom_range(0, 1);
         t  = ptxt[$urandom_range(0, 9)];
         if (t.len() < 2 || $urandom_range(0, 3) == 0) begin
            add(ri, t, 0, 0);
         end else begin
            add(ri, t, $urandom_range(1, t.len() - 1),
                $urandom_range(1, MS + 1));
         end
      end
      run_phase("random_mix");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
